// File: rtl/vid_cfg_master.sv
// vid_cfg_master: bus initiator that programs video-controller registers.
// Local writes are queued in a small FIFO. Each entry then bids for the
// arbiter, sends an address beat and a data beat, and waits for the write
// response from the target.
// Optional feature macro: VCFG_TIMEOUT_EN enables the response timeout and
// the sticky err flag. Without it, RESP waits forever and err stays 0.
module vid_cfg_master #(
  parameter int         DEPTH   = 4,
  parameter logic [1:0] PRIO    = 2'b11,
  parameter int         TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_tar,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [3:0]  reqtar,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_WRREQ = 3'b100;
  localparam logic [2:0] CMD_WRDAT = 3'b011;
  localparam logic [2:0] CMD_WRRSP = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    RESP = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [3:0]  tarMem  [DEPTH];
  logic [31:0] addrMem [DEPTH];
  logic [31:0] dataMem [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;

  state_t state_q;
  state_t state_d;

  logic push;
  logic pop;
  logic empty;
  logic full;
  logic respSeen;
  logic timeoutHit;
  logic bidding;
  logic [3:0]  headTar;
  logic [31:0] headAddr;
  logic [31:0] headData;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign pop      = (state_q == DATA);
  assign respSeen = selin && (cmdin == CMD_WRRSP);
  assign busy     = (state_q != IDLE) || !empty;
  assign lenout   = 2'b00;

  assign headTar  = tarMem[rdPtr_q];
  assign headAddr = addrMem[rdPtr_q];
  assign headData = dataMem[rdPtr_q];

  // The arbiter bid is held from REQ through the last data beat.
  assign bidding  = (state_d == REQ) || (state_d == ADDR) || (state_d == DATA);

  // FIFO payload write; storage needs no reset because the pointers gate it
  always_ff @(posedge clk) begin
    if (push) begin
      tarMem[wrPtr_q]  <= wr_tar;
      addrMem[wrPtr_q] <= wr_addr;
      dataMem[wrPtr_q] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef VCFG_TIMEOUT_EN
  logic [CW-1:0] cnt_q;

  // A response on the same cycle as the limit wins, so the timeout is gated by it
  assign timeoutHit = (state_q == RESP) && !respSeen && ((cnt_q + CW'(1)) == CW'(TIMEOUT));

  // RESP wait counter and sticky error flag; setting beats clearing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      if (state_q == DATA) begin
        cnt_q <= '0;
      end else if (state_q == RESP) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (timeoutHit) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end
`else
  logic [CW:0] unusedTieoff;

  assign unusedTieoff = {err_clr, CW'(TIMEOUT)};
  assign timeoutHit   = 1'b0;
  assign err          = 1'b0;
`endif

  // Next-state selection for the transaction sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = REQ;
      REQ:     if (ackin) state_d = ADDR;
      ADDR:    state_d = DATA;
      DATA:    state_d = RESP;
      RESP:    if (respSeen || timeoutHit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with bus outputs decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      reqout      <= 2'b00;
      reqtar      <= 4'h0;
      cmdout      <= CMD_IDLE;
      addrdataout <= 32'h0;
      done        <= 1'b0;
    end else begin
      state_q <= state_d;
      reqout  <= bidding ? PRIO : 2'b00;
      reqtar  <= bidding ? headTar : 4'h0;
      case (state_d)
        ADDR: begin
          cmdout      <= CMD_WRREQ;
          addrdataout <= headAddr;
        end
        DATA: begin
          cmdout      <= CMD_WRDAT;
          addrdataout <= headData;
        end
        default: begin
          cmdout      <= CMD_IDLE;
          addrdataout <= 32'h0;
        end
      endcase
      done <= (state_q == RESP) && respSeen;
    end
  end

endmodule

// File: tb/tb_vid_cfg_master.sv
// tb_vid_cfg_master: self-checking bench for vid_cfg_master.
// A transaction-level model (entry queue plus a stage number) predicts every
// output each cycle; directed sequences add hand-computed expectations.
// Timeout expectations follow the VCFG_TIMEOUT_EN macro.
module tb_vid_cfg_master;

  localparam int         DEPTH   = 4;
  localparam logic [1:0] PRIO    = 2'b11;
  localparam int         TIMEOUT = 10;
`ifdef VCFG_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_tar;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        selin;
  logic [2:0]  cmdin;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic        busy;
  logic        done;
  logic        err;
  logic        err_clr;

  int total = 0;
  int bad   = 0;

  vid_cfg_master #(.DEPTH(DEPTH), .PRIO(PRIO), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_tar(wr_tar), .wr_addr(wr_addr), .wr_data(wr_data),
    .selin(selin), .cmdin(cmdin), .ackin(ackin),
    .reqout(reqout), .reqtar(reqtar), .cmdout(cmdout), .lenout(lenout),
    .addrdataout(addrdataout), .busy(busy), .done(done), .err(err),
    .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stage numbers describe where the head entry is in its bus transaction
  localparam int ST_IDLE = 0;
  localparam int ST_BID  = 1;
  localparam int ST_ADDR = 2;
  localparam int ST_DATA = 3;
  localparam int ST_RESP = 4;

  typedef struct packed {
    logic [3:0]  tar;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t mq[$];
  int     stage    = ST_IDLE;
  int     respWait = 0;
  bit     errM     = 1'b0;
  bit     doneM    = 1'b0;

  logic [31:0] seenAddr[$];
  int          doneCount = 0;
  logic [31:0] regAddr [5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: advances one step per clock from the inputs alone
  always @(posedge clk or posedge reset) begin : modelProc
    bit pushOk;
    bit expired;
    entry_t e;
    if (reset) begin
      mq.delete();
      stage    = ST_IDLE;
      respWait = 0;
      errM     = 1'b0;
      doneM    = 1'b0;
    end else begin
      pushOk  = wr_valid && (mq.size() < DEPTH);
      expired = 1'b0;
      doneM   = 1'b0;
      case (stage)
        ST_IDLE: if (mq.size() > 0) stage = ST_BID;
        ST_BID:  if (ackin) stage = ST_ADDR;
        ST_ADDR: stage = ST_DATA;
        ST_DATA: begin
          void'(mq.pop_front());
          respWait = 0;
          stage    = ST_RESP;
        end
        ST_RESP: begin
          if (selin && cmdin == 3'b101) begin
            doneM = 1'b1;
            stage = ST_IDLE;
          end else if (TEN) begin
            respWait++;
            if (respWait == TIMEOUT) begin
              expired = 1'b1;
              stage   = ST_IDLE;
            end
          end
        end
        default: stage = ST_IDLE;
      endcase
      if (expired) errM = 1'b1;
      else if (err_clr && TEN) errM = 1'b0;
      if (pushOk) begin
        e.tar  = wr_tar;
        e.addr = wr_addr;
        e.data = wr_data;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, just after the edge
  always @(posedge clk) begin : cmpProc
    entry_t h;
    bit inBid;
    logic [2:0]  expCmd;
    logic [31:0] expAd;
    #1;
    if (!reset) begin
      inBid = (stage == ST_BID) || (stage == ST_ADDR) || (stage == ST_DATA);
      h = (mq.size() > 0) ? mq[0] : '0;
      expCmd = (stage == ST_ADDR) ? 3'b100 : (stage == ST_DATA) ? 3'b011 : 3'b000;
      expAd  = (stage == ST_ADDR) ? h.addr : (stage == ST_DATA) ? h.data : 32'h0;
      checkOutput("m_reqout", 32'(reqout), inBid ? 32'(PRIO) : 32'd0);
      checkOutput("m_reqtar", 32'(reqtar), inBid ? 32'(h.tar) : 32'd0);
      checkOutput("m_cmdout", 32'(cmdout), 32'(expCmd));
      checkOutput("m_lenout", 32'(lenout), 32'd0);
      checkOutput("m_addrdata", addrdataout, expAd);
      checkOutput("m_busy", 32'(busy), 32'((stage != ST_IDLE) || (mq.size() > 0)));
      checkOutput("m_done", 32'(done), 32'(doneM));
      checkOutput("m_err", 32'(err), 32'(errM));
      checkOutput("m_wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
    end
  end

  // Independent record of address beats and completions for ordering checks
  always @(posedge clk) begin
    #1;
    if (!reset && cmdout == 3'b100) seenAddr.push_back(addrdataout);
    if (!reset && done) doneCount++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  // One cycle of stimulus; a push offered this cycle is withdrawn once accepted
  task automatic tick();
    bit willPush;
    willPush = wr_valid && wr_ready;
    @(negedge clk);
    if (willPush) wr_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] tar, input logic [31:0] addr, input logic [31:0] data);
    wr_tar   = tar;
    wr_addr  = addr;
    wr_data  = data;
    wr_valid = 1'b1;
    tick();
  endtask

  task automatic waitBid();
    int n;
    n = 0;
    while (reqout == 2'b00 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("bidSeen", 32'(reqout != 2'b00), 32'd1);
  endtask

  task automatic serviceOne(input int ackDelay, input int respDelay);
    waitBid();
    repeat (ackDelay) tick();
    ackin = 1'b1;
    tick();
    ackin = 1'b0;
    tick();
    tick();
    repeat (respDelay) begin
      selin = 1'($urandom_range(0, 1));
      cmdin = 3'($urandom_range(0, 4));
      tick();
    end
    selin = 1'b1;
    cmdin = 3'b101;
    tick();
    selin = 1'b0;
    cmdin = 3'b000;
  endtask

  initial begin
    regAddr[0] = 32'h00;
    regAddr[1] = 32'h28;
    regAddr[2] = 32'h30;
    regAddr[3] = 32'h38;
    regAddr[4] = 32'h40;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_tar   = 4'h0;
    wr_addr  = 32'h0;
    wr_data  = 32'h0;
    selin    = 1'b0;
    cmdin    = 3'b000;
    ackin    = 1'b0;
    err_clr  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_reqout", 32'(reqout), 32'd0);
    checkOutput("rst_cmdout", 32'(cmdout), 32'd0);
    checkOutput("rst_addrdata", addrdataout, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();

    // Single write, full handshake
    applyStimulus(4'd1, 32'h28, 32'h00A0_1320);
    checkOutput("t1_busyAfterPush", 32'(busy), 32'd1);
    checkOutput("t1_noBidYet", 32'(reqout), 32'd0);
    tick();
    checkOutput("t1_bidPrio", 32'(reqout), 32'd3);
    checkOutput("t1_bidTar", 32'(reqtar), 32'd1);
    ackin = 1'b1;
    tick();
    ackin = 1'b0;
    checkOutput("t1_addrCmd", 32'(cmdout), 32'h4);
    checkOutput("t1_addrBeat", addrdataout, 32'h28);
    tick();
    checkOutput("t1_dataCmd", 32'(cmdout), 32'h3);
    checkOutput("t1_dataBeat", addrdataout, 32'h00A0_1320);
    checkOutput("t1_dataReq", 32'(reqout), 32'd3);
    tick();
    checkOutput("t1_respReq", 32'(reqout), 32'd0);
    checkOutput("t1_respCmd", 32'(cmdout), 32'd0);
    selin = 1'b1;
    cmdin = 3'b101;
    tick();
    selin = 1'b0;
    cmdin = 3'b000;
    checkOutput("t1_donePulse", 32'(done), 32'd1);
    checkOutput("t1_busyFalls", 32'(busy), 32'd0);
    tick();
    checkOutput("t1_doneOnce", 32'(done), 32'd0);

    // Long arbitration wait, then a non-response command in RESP
    applyStimulus(4'd2, 32'h30, 32'h0000_1234);
    waitBid();
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("t2_holdReq", 32'(reqout), 32'd3);
      checkOutput("t2_holdCmd", 32'(cmdout), 32'd0);
    end
    ackin = 1'b1;
    tick();
    ackin = 1'b0;
    checkOutput("t2_addrAfterAck", 32'(cmdout), 32'h4);
    tick();
    tick();
    selin = 1'b1;
    cmdin = 3'b100;
    repeat (3) begin
      tick();
      checkOutput("t5_wrongCmd", 32'(done), 32'd0);
    end
    cmdin = 3'b101;
    tick();
    selin = 1'b0;
    cmdin = 3'b000;
    checkOutput("t5_rightCmd", 32'(done), 32'd1);
    tick();

    // Fill past DEPTH, then drain in push order
    seenAddr.delete();
    doneCount = 0;
    for (int k = 0; k < 4; k++) applyStimulus(4'(k + 3), regAddr[k], $urandom);
    checkOutput("t3_fullReady", 32'(wr_ready), 32'd0);
    wr_tar   = 4'd7;
    wr_addr  = regAddr[4];
    wr_data  = $urandom;
    wr_valid = 1'b1;
    repeat (3) begin
      tick();
      checkOutput("t3_heldFull", 32'(wr_ready), 32'd0);
    end
    for (int k = 0; k < 5; k++) serviceOne($urandom_range(0, 3), $urandom_range(0, 6));
    tick();
    checkOutput("t3_doneCount", 32'(doneCount), 32'd5);
    checkOutput("t3_addrCount", 32'(seenAddr.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < seenAddr.size()) checkOutput("t3_addrOrder", seenAddr[k], regAddr[k]);
    end

    // Missing response
    applyStimulus(4'd5, 32'h48, 32'h8000_0000);
    applyStimulus(4'd6, 32'h50, 32'h0000_0A00);
    waitBid();
    ackin = 1'b1;
    tick();
    ackin = 1'b0;
    tick();
    tick();
    checkOutput("t4_errStart", 32'(err), 32'd0);
`ifdef VCFG_TIMEOUT_EN
    repeat (TIMEOUT - 1) tick();
    checkOutput("t4_errEarly", 32'(err), 32'd0);
    tick();
    checkOutput("t4_errSet", 32'(err), 32'd1);
    checkOutput("t4_noDone", 32'(done), 32'd0);
    tick();
    checkOutput("t4_nextBid", 32'(reqout), 32'd3);
    checkOutput("t4_nextTar", 32'(reqtar), 32'd6);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("t4_errClr", 32'(err), 32'd0);
    serviceOne(0, 2);
`else
    err_clr = 1'b1;
    repeat (30) tick();
    err_clr = 1'b0;
    checkOutput("t4_errTied", 32'(err), 32'd0);
    checkOutput("t4_stillWaiting", 32'(busy), 32'd1);
    checkOutput("t4_noDone", 32'(done), 32'd0);
    selin = 1'b1;
    cmdin = 3'b101;
    tick();
    selin = 1'b0;
    cmdin = 3'b000;
    checkOutput("t4_lateDone", 32'(done), 32'd1);
    serviceOne(0, 2);
`endif
    tick();

    // Reset in the middle of the data beat
    applyStimulus(4'd8, 32'h38, 32'h1111_2222);
    applyStimulus(4'd9, 32'h40, 32'h3333_4444);
    waitBid();
    ackin = 1'b1;
    tick();
    ackin = 1'b0;
    tick();
    checkOutput("t6_inData", 32'(cmdout), 32'h3);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_rstReq", 32'(reqout), 32'd0);
    checkOutput("t6_rstCmd", 32'(cmdout), 32'd0);
    checkOutput("t6_rstAd", addrdataout, 32'd0);
    checkOutput("t6_rstTar", 32'(reqtar), 32'd0);
    checkOutput("t6_rstBusy", 32'(busy), 32'd0);
    checkOutput("t6_rstReady", 32'(wr_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      tick();
      checkOutput("t6_noBid", 32'(reqout), 32'd0);
      checkOutput("t6_empty", 32'(busy), 32'd0);
    end

    // Randomised traffic against the model, with one reset pulse
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset    = (c == 1500);
      wr_valid = ($urandom_range(0, 99) < 35);
      wr_tar   = 4'($urandom);
      wr_addr  = $urandom;
      wr_data  = $urandom;
      ackin    = ($urandom_range(0, 99) < 40);
      selin    = ($urandom_range(0, 99) < 30);
      cmdin    = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'($urandom);
      err_clr  = ($urandom_range(0, 99) < 5);
    end
    @(negedge clk);
    reset    = 1'b0;
    wr_valid = 1'b0;
    err_clr  = 1'b0;
    ackin    = 1'b1;
    selin    = 1'b1;
    cmdin    = 3'b101;
    repeat (60) @(negedge clk);
    checkOutput("drain_idle", 32'(busy), 32'd0);
    ackin = 1'b0;
    selin = 1'b0;
    cmdin = 3'b000;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
